// File: rtl/sync_fifo_gen_pkg.sv
// Shared constants and helpers for the generic synchronous FIFO.
package sync_fifo_gen_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON  = 1'b1;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_gen_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module sync_fifo_gen_mem #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  // Contents are deliberately not reset.
  logic [Width-1:0] mem_q [Depth];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational so FWFT can expose the head entry directly.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_gen.sv
// Generic single-clock FIFO: configurable width/depth (any depth >= 2), almost-flag
// thresholds, synchronous flush, occupancy count and optional first-word-fall-through.
module sync_fifo_gen
  import sync_fifo_gen_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  parameter bit          FWFT       = FWFT_OFF,
  localparam int unsigned CntW      = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [FIFO_WIDTH-1:0] data_in_i,
  output logic [FIFO_WIDTH-1:0] data_out_o,
  output logic                  rd_valid_o,
  output logic                  wr_ack_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almostfull_o,
  output logic                  almostempty_o,
  output logic [CntW-1:0]       count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  // Reject configurations whose flags or pointers would be meaningless.
  if (FIFO_DEPTH < 2) begin : gen_depth_chk
    $fatal(1, "sync_fifo_gen: FIFO_DEPTH must be at least 2");
  end
  if (AF_THRESH > FIFO_DEPTH) begin : gen_af_chk
    $fatal(1, "sync_fifo_gen: AF_THRESH must not exceed FIFO_DEPTH");
  end
  if (AE_THRESH >= FIFO_DEPTH) begin : gen_ae_chk
    $fatal(1, "sync_fifo_gen: AE_THRESH must be below FIFO_DEPTH");
  end

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic                  wr_accept, rd_accept;
  logic                  mem_we;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  // Pointers wrap at FIFO_DEPTH-1 rather than at a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Occupancy flags and transfer qualification.
  always_comb begin
    full      = (count_q == CntW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    wr_accept = wr_en_i && (!full || rd_en_i);
    rd_accept = rd_en_i && !empty;
    // Reset and flush both suppress the array write.
    mem_we    = wr_accept && !rst_i && !flush_i;
  end

  sync_fifo_gen_mem #(
    .Width (FIFO_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state for pointers, occupancy, read data and the one-cycle status pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (flush_i) begin
      // Flush empties the FIFO but keeps the last read word visible.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_accept) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        data_out_d = mem_rdata;
        rd_valid_d = 1'b1;
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      wr_ack_d    = wr_accept;
      overflow_d  = wr_en_i && !wr_accept;
      underflow_d = rd_en_i && empty;
    end
  end

  // State register with synchronous active-high reset; reset wins over flush and traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output selection: FWFT exposes the head entry, otherwise the registered read word.
  always_comb begin
    if (FWFT == FWFT_ON) begin
      data_out_o = mem_rdata;
      rd_valid_o = !empty;
    end else begin
      data_out_o = data_out_q;
      rd_valid_o = rd_valid_q;
    end
    wr_ack_o      = wr_ack_q;
    overflow_o    = overflow_q;
    underflow_o   = underflow_q;
    full_o        = full;
    empty_o       = empty;
    almostfull_o  = (count_q >= CntW'(AF_THRESH));
    almostempty_o = (count_q <= CntW'(AE_THRESH));
    count_o       = count_q;
  end

  // Structural invariants: occupancy and pointers stay within the array.
  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CntW'(FIFO_DEPTH));
  a_wr_ptr_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    wr_ptr_q <= PtrW'(FIFO_DEPTH - 1));
  a_rd_ptr_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    rd_ptr_q <= PtrW'(FIFO_DEPTH - 1));

endmodule
